// File: rtl/core2_dct_pkg.sv
// Shared widths, state encoding, atom codes and frame payload for the DCT trace sequencer.
package core2_dct_pkg;

  localparam int unsigned ATOM_W    = 2;
  localparam int unsigned NUM_ATOMS = 15;
  localparam int unsigned BUF_W     = ATOM_W * NUM_ATOMS;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned DROP_W    = 8;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    ENDED = 2'd2
  } state_e;

  // Plain-vector views of the state enum for the legacy-style FSM register.
  localparam logic [1:0] ST_RUN   = 2'(RUN);
  localparam logic [1:0] ST_FLUSH = 2'(FLUSH);
  localparam logic [1:0] ST_ENDED = 2'(ENDED);

  localparam logic [ATOM_W-1:0] NT  = 2'b00;
  localparam logic [ATOM_W-1:0] TK  = 2'b01;
  localparam logic [ATOM_W-1:0] EXC = 2'b10;
  localparam logic [ATOM_W-1:0] RSV = 2'b11;

  typedef struct packed {
    logic [BUF_W-1:0] data;
    logic [CNT_W-1:0] count;
  } frame_t;

endpackage

// File: rtl/core2_dct_if.sv
// Atom input, frame output and monitor signals of the DCT trace sequencer.
interface core2_dct_if;
  import core2_dct_pkg::*;

  logic               atom_valid;
  logic [ATOM_W-1:0]  atom_data;
  logic               atom_ready;
  logic               flush_req;
  logic               test_ending;
  logic               frame_valid;
  logic               frame_ready;
  logic [BUF_W-1:0]   frame_data;
  logic [CNT_W-1:0]   frame_count;
  logic [BUF_W-1:0]   dct_buffer;
  logic [CNT_W-1:0]   dct_count;
  logic               test_has_ended;
  logic [DROP_W-1:0]  drop_count;

  modport master (
    output atom_valid, atom_data, flush_req, test_ending, frame_ready,
    input  atom_ready, frame_valid, frame_data, frame_count,
           dct_buffer, dct_count, test_has_ended, drop_count
  );

  modport slave (
    input  atom_valid, atom_data, flush_req, test_ending, frame_ready,
    output atom_ready, frame_valid, frame_data, frame_count,
           dct_buffer, dct_count, test_has_ended, drop_count
  );

endinterface

// File: rtl/core2_dct_frame_slot.sv
// Single-entry valid/ready output register for finished DCT frames.
module core2_dct_frame_slot
  import core2_dct_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  frame_t load_frame,
  input  logic   ready,
  output logic   valid,
  output frame_t frame,
  output logic   slot_free_c
);

  logic   valid_q, valid_d;
  frame_t frame_q, frame_d;

  assign slot_free_c = !valid_q | ready;

  // A load always wins over a drain so frames can stream back to back.
  always_comb begin
    valid_d = valid_q;
    frame_d = frame_q;
    if (load) begin
      valid_d = 1'b1;
      frame_d = load_frame;
    end else if (ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      frame_q <= '0;
    end else begin
      valid_q <= valid_d;
      frame_q <= frame_d;
    end
  end

  assign valid = valid_q;
  assign frame = frame_q;

endmodule

// File: rtl/core2_dct_trace_sequencer.sv
// Packs 2-bit branch trace atoms into 15-atom frames and sequences the end-of-test drain.
module core2_dct_trace_sequencer
  import core2_dct_pkg::*;
(
  input logic         clk,
  input logic         reset,
  core2_dct_if.slave  bus
);

  logic [1:0]        state_q, state_d;
  logic              live_q, live_d;
  logic [BUF_W-1:0]  buf_q, buf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              flush_pending_q, flush_pending_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic   in_run_c, full_c, slot_free_c, xfer_c, ready_c, acc_c;
  logic   slot_valid;
  frame_t slot_frame, xfer_frame;

  // live_q holds atom_ready low for the first cycle after reset releases.
  assign in_run_c = live_q & (state_q == ST_RUN);
  assign full_c   = (cnt_q == CNT_W'(NUM_ATOMS));
  assign xfer_c   = slot_free_c &
                    (full_c | ((flush_pending_q | (state_q == ST_FLUSH)) & (cnt_q != '0)));
  assign ready_c  = in_run_c & (!full_c | xfer_c);
  assign acc_c    = bus.atom_valid & ready_c;

  assign xfer_frame = '{data: buf_q, count: cnt_q};

  always_comb begin
    state_d         = state_q;
    live_d          = 1'b1;
    buf_d           = buf_q;
    cnt_d           = cnt_q;
    flush_pending_d = flush_pending_q;
    drop_d          = drop_q;

    // Transfer clears first so a same-cycle atom starts the next frame.
    if (xfer_c) begin
      buf_d = '0;
      cnt_d = '0;
    end
    if (acc_c) begin
      buf_d = {buf_d[BUF_W-ATOM_W-1:0], bus.atom_data};
      cnt_d = cnt_d + CNT_W'(1);
    end

    if (in_run_c & bus.flush_req) begin
      flush_pending_d = 1'b1;
    end else if (flush_pending_q & (xfer_c | ((cnt_q == '0) & !acc_c))) begin
      flush_pending_d = 1'b0;
    end

    if (in_run_c & bus.atom_valid & !ready_c & (drop_q != '1)) begin
      drop_d = drop_q + DROP_W'(1);
    end

    case (state_q)
      ST_RUN:   if (live_q & bus.test_ending) state_d = ST_FLUSH;
      ST_FLUSH: if ((cnt_q == '0) & !slot_valid) state_d = ST_ENDED;
      ST_ENDED: state_d = ST_ENDED;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_RUN;
      live_q          <= 1'b0;
      buf_q           <= '0;
      cnt_q           <= '0;
      flush_pending_q <= 1'b0;
      drop_q          <= '0;
    end else begin
      state_q         <= state_d;
      live_q          <= live_d;
      buf_q           <= buf_d;
      cnt_q           <= cnt_d;
      flush_pending_q <= flush_pending_d;
      drop_q          <= drop_d;
    end
  end

  core2_dct_frame_slot u_slot (
    .clk         (clk),
    .reset       (reset),
    .load        (xfer_c),
    .load_frame  (xfer_frame),
    .ready       (bus.frame_ready),
    .valid       (slot_valid),
    .frame       (slot_frame),
    .slot_free_c (slot_free_c)
  );

  assign bus.atom_ready     = ready_c;
  assign bus.frame_valid    = slot_valid;
  assign bus.frame_data     = slot_frame.data;
  assign bus.frame_count    = slot_frame.count;
  assign bus.dct_buffer     = buf_q;
  assign bus.dct_count      = cnt_q;
  assign bus.test_has_ended = (state_q == ST_ENDED);
  assign bus.drop_count     = drop_q;

endmodule

// File: tb/tb_core2_dct_trace_sequencer.sv
// Directed bench for the DCT trace sequencer with hand-computed frame values.
module tb_core2_dct_trace_sequencer;
  import core2_dct_pkg::*;

  logic clk = 1'b0;
  logic reset;

  core2_dct_if bus ();

  core2_dct_trace_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.atom_valid  = 1'b0;
    bus.atom_data   = NT;
    bus.flush_req   = 1'b0;
    bus.test_ending = 1'b0;
    bus.frame_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_fvalid"}, 32'(bus.frame_valid), 32'h0);
    check_eq({tag, "_fdata"},  32'(bus.frame_data), 32'h0);
    check_eq({tag, "_fcount"}, 32'(bus.frame_count), 32'h0);
    check_eq({tag, "_buf"},    32'(bus.dct_buffer), 32'h0);
    check_eq({tag, "_cnt"},    32'(bus.dct_count), 32'h0);
    check_eq({tag, "_ended"},  32'(bus.test_has_ended), 32'h0);
    check_eq({tag, "_drop"},   32'(bus.drop_count), 32'h0);
    check_eq({tag, "_ready"},  32'(bus.atom_ready), 32'h0);
  endtask

  initial begin
    // Reset state, checked while reset is still asserted.
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    check_all_zero("rst");
    reset = 1'b0;
    step();
    check_eq("rst_ready_after", 32'(bus.atom_ready), 32'h1);

    // Fill: 15 TK atoms then a 16th accepted in the transfer cycle.
    bus.frame_ready = 1'b1;
    bus.atom_valid  = 1'b1;
    bus.atom_data   = TK;
    for (int i = 0; i < 15; i++) step();
    check_eq("fill_cnt15",   32'(bus.dct_count), 32'd15);
    check_eq("fill_buf",     32'(bus.dct_buffer), 32'h15555555);
    check_eq("fill_fv0",     32'(bus.frame_valid), 32'h0);
    check_eq("fill_ready16", 32'(bus.atom_ready), 32'h1);
    step();
    bus.atom_valid = 1'b0;
    check_eq("fill_fv",     32'(bus.frame_valid), 32'h1);
    check_eq("fill_fdata",  32'(bus.frame_data), 32'h15555555);
    check_eq("fill_fcount", 32'(bus.frame_count), 32'd15);
    check_eq("fill_cnt1",   32'(bus.dct_count), 32'd1);
    check_eq("fill_buf1",   32'(bus.dct_buffer), 32'h1);
    step();
    check_eq("fill_drain", 32'(bus.frame_valid), 32'h0);

    // Partial flush of NT,TK,EXC, then a flush with nothing collected.
    do_reset();
    bus.frame_ready = 1'b1;
    bus.atom_valid  = 1'b1;
    bus.atom_data   = NT;  step();
    bus.atom_data   = TK;  step();
    bus.atom_data   = EXC; step();
    bus.atom_valid  = 1'b0;
    bus.flush_req   = 1'b1;
    step();
    bus.flush_req = 1'b0;
    check_eq("pf_cnt3", 32'(bus.dct_count), 32'd3);
    check_eq("pf_fv0",  32'(bus.frame_valid), 32'h0);
    step();
    check_eq("pf_fv",     32'(bus.frame_valid), 32'h1);
    check_eq("pf_fdata",  32'(bus.frame_data), 32'h6);
    check_eq("pf_fcount", 32'(bus.frame_count), 32'd3);
    check_eq("pf_cnt0",   32'(bus.dct_count), 32'd0);
    step();
    check_eq("pf_drain", 32'(bus.frame_valid), 32'h0);
    bus.flush_req = 1'b1;
    step();
    bus.flush_req = 1'b0;
    step();
    check_eq("pf_empty_a", 32'(bus.frame_valid), 32'h0);
    step();
    check_eq("pf_empty_b", 32'(bus.frame_valid), 32'h0);

    // Full buffer with a simultaneous flush gives a single 15-atom frame.
    do_reset();
    bus.atom_valid = 1'b1;
    bus.atom_data  = TK;
    for (int i = 0; i < 15; i++) step();
    bus.atom_valid = 1'b0;
    bus.flush_req  = 1'b1;
    step();
    bus.flush_req = 1'b0;
    check_eq("ff_fv",     32'(bus.frame_valid), 32'h1);
    check_eq("ff_fcount", 32'(bus.frame_count), 32'd15);
    check_eq("ff_cnt0",   32'(bus.dct_count), 32'd0);
    bus.frame_ready = 1'b1;
    step();
    step();
    check_eq("ff_single", 32'(bus.frame_valid), 32'h0);

    // Backpressure: 32 atoms (k mod 4) with the slot blocked.
    do_reset();
    for (int k = 0; k < 32; k++) begin
      bus.atom_valid = 1'b1;
      bus.atom_data  = 2'(k % 4);
      step();
    end
    bus.atom_valid = 1'b0;
    check_eq("bp_fv",     32'(bus.frame_valid), 32'h1);
    check_eq("bp_fdata1", 32'(bus.frame_data), 32'h06C6C6C6);
    check_eq("bp_cnt15",  32'(bus.dct_count), 32'd15);
    check_eq("bp_buf",    32'(bus.dct_buffer), 32'h31B1B1B1);
    check_eq("bp_ready0", 32'(bus.atom_ready), 32'h0);
    check_eq("bp_drop2",  32'(bus.drop_count), 32'd2);
    bus.frame_ready = 1'b1;
    step();
    check_eq("bp_fv2",     32'(bus.frame_valid), 32'h1);
    check_eq("bp_fdata2",  32'(bus.frame_data), 32'h31B1B1B1);
    check_eq("bp_fcount2", 32'(bus.frame_count), 32'd15);
    check_eq("bp_cnt0",    32'(bus.dct_count), 32'd0);
    step();
    check_eq("bp_drain", 32'(bus.frame_valid), 32'h0);

    // End of test: 5-atom frame, then the sticky ended flag.
    do_reset();
    bus.frame_ready = 1'b1;
    bus.atom_valid  = 1'b1;
    bus.atom_data   = EXC; step();
    bus.atom_data   = TK;  step();
    bus.atom_data   = NT;  step();
    bus.atom_data   = RSV; step();
    bus.atom_data   = TK;  step();
    bus.atom_valid  = 1'b0;
    bus.test_ending = 1'b1;
    step();
    bus.test_ending = 1'b0;
    check_eq("eot_cnt5",   32'(bus.dct_count), 32'd5);
    check_eq("eot_ready0", 32'(bus.atom_ready), 32'h0);
    bus.atom_valid = 1'b1;
    bus.atom_data  = TK;
    step();
    check_eq("eot_fv",     32'(bus.frame_valid), 32'h1);
    check_eq("eot_fdata",  32'(bus.frame_data), 32'h24D);
    check_eq("eot_fcount", 32'(bus.frame_count), 32'd5);
    step();
    check_eq("eot_fv0",     32'(bus.frame_valid), 32'h0);
    check_eq("eot_not_yet", 32'(bus.test_has_ended), 32'h0);
    step();
    check_eq("eot_ended", 32'(bus.test_has_ended), 32'h1);
    check_eq("eot_drop0", 32'(bus.drop_count), 32'd0);
    check_eq("eot_cnt0",  32'(bus.dct_count), 32'd0);
    bus.flush_req   = 1'b1;
    bus.test_ending = 1'b1;
    for (int i = 0; i < 3; i++) step();
    bus.atom_valid  = 1'b0;
    bus.flush_req   = 1'b0;
    bus.test_ending = 1'b0;
    check_eq("eot_sticky",  32'(bus.test_has_ended), 32'h1);
    check_eq("eot_noframe", 32'(bus.frame_valid), 32'h0);
    check_eq("eot_drop_hold", 32'(bus.drop_count), 32'd0);

    // Reset mid-operation discards the frame and its pending flush.
    do_reset();
    bus.frame_ready = 1'b1;
    bus.atom_valid  = 1'b1;
    bus.atom_data   = TK;
    for (int i = 0; i < 7; i++) step();
    bus.atom_valid = 1'b0;
    bus.flush_req  = 1'b1;
    step();
    bus.flush_req = 1'b0;
    reset = 1'b1;
    step();
    check_all_zero("mid");
    reset = 1'b0;
    step();
    check_eq("mid_fv0",   32'(bus.frame_valid), 32'h0);
    check_eq("mid_ready", 32'(bus.atom_ready), 32'h1);
    bus.atom_valid = 1'b1;
    step();
    bus.atom_valid = 1'b0;
    check_eq("mid_cnt1", 32'(bus.dct_count), 32'd1);
    step();
    step();
    check_eq("mid_noflush", 32'(bus.frame_valid), 32'h0);

    // Drop counter saturation with the slot blocked.
    do_reset();
    bus.atom_valid = 1'b1;
    bus.atom_data  = RSV;
    for (int i = 0; i < 280; i++) step();
    check_eq("sat_250", 32'(bus.drop_count), 32'd250);
    for (int i = 0; i < 20; i++) step();
    bus.atom_valid = 1'b0;
    check_eq("sat_255", 32'(bus.drop_count), 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
